// File: rtl/shift_rotate_ctrl_if.sv
// Handshake bundle for the shared shift/rotate unit: two requester channels and one result channel.
// The master side belongs to the requesters and the result consumer; the slave side belongs to the unit.
interface shift_rotate_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  req0_valid;
   logic                  req0_ready;
   logic [2:0]            req0_op;
   logic [DATA_WIDTH-1:0] req0_a;
   logic [DATA_WIDTH-1:0] req0_b;

   logic                  req1_valid;
   logic                  req1_ready;
   logic [2:0]            req1_op;
   logic [DATA_WIDTH-1:0] req1_a;
   logic [DATA_WIDTH-1:0] req1_b;

   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_src;
   logic                  out_illegal;

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      input  req0_ready,
      output req1_valid, req1_op, req1_a, req1_b,
      input  req1_ready,
      input  out_valid, out_data, out_src, out_illegal,
      output out_ready
   );

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      output req0_ready,
      input  req1_valid, req1_op, req1_a, req1_b,
      output req1_ready,
      output out_valid, out_data, out_src, out_illegal,
      input  out_ready
   );
endinterface

// File: rtl/shift_rotate_ctrl.sv
// Shared shift/rotate unit: round-robin arbitration over two requesters, a single rotate-left
// barrel datapath with per-op masking, and a two-stage valid/ready pipeline.
module shift_rotate_ctrl #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input logic               clk,
   input logic               rst_n,
   shift_rotate_ctrl_if.slave bus
);
   localparam int unsigned AW = 5;

   localparam logic [2:0] OP_ROL  = 3'b000;
   localparam logic [2:0] OP_ROR  = 3'b001;
   localparam logic [2:0] OP_SHL  = 3'b010;
   localparam logic [2:0] OP_SHR  = 3'b011;
   localparam logic [2:0] OP_SHRA = 3'b100;

   typedef struct packed {
      logic [2:0]            op;
      logic [DATA_WIDTH-1:0] a;
      logic [AW-1:0]         amt;
      logic                  src;
   } s1_t;

   logic                  s1_valid;
   s1_t                   s1;
   s1_t                   s1_next;
   logic                  last_grant;
   logic                  out_valid_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic                  out_src_q;
   logic                  out_illegal_q;

   logic s2_adv, s1_adv;
   logic grant0, grant1;
   logic acc0, acc1;

   logic                  unused_b_hi;
   logic [AW-1:0]         r;
   logic                  right;
   logic [DATA_WIDTH-1:0] rot;
   logic [DATA_WIDTH-1:0] lo_mask;
   logic [DATA_WIDTH-1:0] hi_mask;
   logic [DATA_WIDTH-1:0] res;
   logic                  illegal;

   assign unused_b_hi = ^{bus.req0_b[DATA_WIDTH-1:AW], bus.req1_b[DATA_WIDTH-1:AW]};

   // Flow control; each grant looks only at the other requester's valid.
   assign s2_adv = !out_valid_q || bus.out_ready;
   assign s1_adv = !s1_valid || s2_adv;
   assign grant0 = !bus.req1_valid || last_grant;
   assign grant1 = !bus.req0_valid || !last_grant;

   assign bus.req0_ready = s1_adv && grant0;
   assign bus.req1_ready = s1_adv && grant1;
   assign acc0 = bus.req0_valid && bus.req0_ready;
   assign acc1 = bus.req1_valid && bus.req1_ready;

   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = out_data_q;
   assign bus.out_src     = out_src_q;
   assign bus.out_illegal = out_illegal_q;

   always_comb begin
      s1_next = '0;
      if (acc1) begin
         s1_next.op  = bus.req1_op;
         s1_next.a   = bus.req1_a;
         s1_next.amt = bus.req1_b[AW-1:0];
         s1_next.src = 1'b1;
      end else begin
         s1_next.op  = bus.req0_op;
         s1_next.a   = bus.req0_a;
         s1_next.amt = bus.req0_b[AW-1:0];
         s1_next.src = 1'b0;
      end
   end

   // Every op is a left rotate; right-going ops rotate by (32-n) mod 32, then mask.
   always_comb begin
      res     = s1.a;
      illegal = 1'b0;
      right   = (s1.op == OP_ROR) || (s1.op == OP_SHR) || (s1.op == OP_SHRA);
      r       = right ? AW'(AW'(0) - s1.amt) : s1.amt;
      rot     = (s1.a << r) | (s1.a >> (6'(DATA_WIDTH) - 6'(r)));
      lo_mask = {DATA_WIDTH{1'b1}} << s1.amt;
      hi_mask = {DATA_WIDTH{1'b1}} >> s1.amt;
      case (s1.op)
         OP_ROL, OP_ROR: res = rot;
         OP_SHL:         res = rot & lo_mask;
         OP_SHR:         res = rot & hi_mask;
         OP_SHRA:        res = (rot & hi_mask) | ({DATA_WIDTH{s1.a[DATA_WIDTH-1]}} & ~hi_mask);
         default: begin
            res     = s1.a;
            illegal = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid   <= 1'b0;
         s1         <= '0;
         last_grant <= 1'b1;
      end else if (s1_adv) begin
         s1_valid <= acc0 || acc1;
         if (acc0 || acc1) begin
            s1         <= s1_next;
            last_grant <= acc1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_src_q     <= 1'b0;
         out_illegal_q <= 1'b0;
      end else if (s2_adv) begin
         out_valid_q <= s1_valid;
         if (s1_valid) begin
            out_data_q    <= res;
            out_src_q     <= s1.src;
            out_illegal_q <= illegal;
         end
      end
   end
endmodule

// File: tb/tb_shift_rotate_ctrl.sv
// Scoreboard bench for shift_rotate_ctrl: expectations are queued at each handshake and
// retired in order against the result channel.
module tb_shift_rotate_ctrl;
   logic clk;
   logic rst_n;

   shift_rotate_ctrl_if #(.DATA_WIDTH(32)) ifc ();

   shift_rotate_ctrl #(.DATA_WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   typedef struct {
      logic [31:0] data;
      logic        src;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      int          n = int'(b[4:0]);
      logic [31:0] r = a;
      case (op)
         3'd0: for (int i = 0; i < 32; i++) r[(i + n) % 32] = a[i];
         3'd1: for (int i = 0; i < 32; i++) r[i] = a[(i + n) % 32];
         3'd2: r = a << n;
         3'd3: r = a >> n;
         3'd4: r = 32'($signed(a) >>> n);
         default: r = a;
      endcase
      return r;
   endfunction

   function automatic exp_t mk(input logic src, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b);
      exp_t e;
      e.data = model(op, a, b);
      e.src  = src;
      e.ill  = (op > 3'd4);
      return e;
   endfunction

   // Retire before enqueue so an empty queue never pairs a result with its own request.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ifc.out_valid && ifc.out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_out", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("out_data", ifc.out_data, e.data);
               chk("out_src", 32'(ifc.out_src), 32'(e.src));
               chk("out_illegal", 32'(ifc.out_illegal), 32'(e.ill));
            end
         end
         if (ifc.req0_valid && ifc.req0_ready)
            sb.push_back(mk(1'b0, ifc.req0_op, ifc.req0_a, ifc.req0_b));
         if (ifc.req1_valid && ifc.req1_ready)
            sb.push_back(mk(1'b1, ifc.req1_op, ifc.req1_a, ifc.req1_b));
      end
   end

   task automatic drive(input int p, input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      if (p == 0) begin
         ifc.req0_valid = v; ifc.req0_op = op; ifc.req0_a = a; ifc.req0_b = b;
      end else begin
         ifc.req1_valid = v; ifc.req1_op = op; ifc.req1_a = a; ifc.req1_b = b;
      end
   endtask

   task automatic issue(input int p, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      int   t   = 0;
      logic got = 1'b0;
      @(posedge clk); #1;
      drive(p, 1'b1, op, a, b);
      while (!got && t < 50) begin
         @(negedge clk);
         got = (p == 0) ? ifc.req0_ready : ifc.req1_ready;
         t++;
      end
      if (!got) chk("issue_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      drive(p, 1'b0, 3'd0, 32'd0, 32'd0);
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 30) begin
         @(negedge clk);
         t++;
      end
      chk("drain_left", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      logic [31:0] held;
      rst_n = 1'b0;
      drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
      drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
      ifc.out_ready = 1'b1;
      #2;
      chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("rst_out_data", ifc.out_data, 32'd0);
      chk("rst_out_src", 32'(ifc.out_src), 32'd0);
      chk("rst_out_illegal", 32'(ifc.out_illegal), 32'd0);
      #20 rst_n = 1'b1;

      // Accept edge, one more edge, then the result is visible.
      @(posedge clk); #1;
      drive(0, 1'b1, 3'd0, 32'h8000_0001, 32'd1);
      @(posedge clk); #1;
      drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
      chk("lat_not_yet", 32'(ifc.out_valid), 32'd0);
      @(posedge clk); #1;
      chk("lat_valid", 32'(ifc.out_valid), 32'd1);
      chk("lat_data", ifc.out_data, 32'h0000_0003);
      drain();

      issue(0, 3'd1, 32'h0000_0001, 32'd4);
      issue(1, 3'd4, 32'h8000_0000, 32'd31);
      issue(0, 3'd3, 32'h8000_0000, 32'd31);
      issue(1, 3'd2, 32'hFFFF_FFFF, 32'd36);
      for (int k = 0; k < 16; k++)
         issue(k % 2, 3'($urandom_range(0, 4)), $urandom, $urandom);
      drain();

      issue(0, 3'd7, 32'h1234_5678, 32'd3);
      for (int op = 0; op < 5; op++) begin
         issue(op % 2, 3'(op), 32'hDEAD_BEEF, 32'd0);
         issue(0, 3'(op), 32'hC0FF_EE01, 32'h0000_0040);
      end
      drain();

      // Stall with two ops in flight; a third request must not be taken.
      @(posedge clk); #1;
      ifc.out_ready = 1'b0;
      issue(0, 3'd0, 32'h0000_00F0, 32'd8);
      issue(0, 3'd2, 32'h0000_0F0F, 32'd4);
      drive(1, 1'b1, 3'd1, 32'hA5A5_0000, 32'd16);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("stall_valid", 32'(ifc.out_valid), 32'd1);
         held = (sb.size() != 0) ? sb[0].data : 32'hxxxx_xxxx;
         chk("stall_data", ifc.out_data, held);
         chk("stall_rdy0", 32'(ifc.req0_ready), 32'd0);
         chk("stall_rdy1", 32'(ifc.req1_ready), 32'd0);
      end
      @(posedge clk); #1;
      ifc.out_ready = 1'b1;
      begin
         int   t   = 0;
         logic got = 1'b0;
         while (!got && t < 20) begin
            @(negedge clk);
            got = ifc.req1_ready;
            t++;
         end
         if (!got) chk("stall_release_timeout", 32'd0, 32'd1);
         @(posedge clk); #1;
         drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
      end
      drain();

      // Contention every cycle: last winner was req1, so grants go 0,1,0,1,...
      @(posedge clk); #1;
      drive(0, 1'b1, 3'd0, 32'h0000_1000, 32'd1);
      drive(1, 1'b1, 3'd1, 32'h0000_2000, 32'd1);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("rr_rdy0", 32'(ifc.req0_ready), 32'(k % 2 == 0));
         chk("rr_rdy1", 32'(ifc.req1_ready), 32'(k % 2 == 1));
         @(posedge clk); #1;
         if (k % 2 == 0) drive(0, 1'b1, 3'd2, 32'h0000_1001 + 32'(k), 32'(k + 1));
         else            drive(1, 1'b1, 3'd3, 32'h8000_2000 + 32'(k), 32'(k + 1));
      end
      drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
      drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
      drain();

      // req0 streams so last_grant points at req0; reset must return it to favouring req0.
      @(posedge clk); #1;
      drive(0, 1'b1, 3'd0, 32'h0F0F_0F0F, 32'd3);
      repeat (3) @(posedge clk);
      @(negedge clk); #2;
      rst_n = 1'b0;
      drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
      #1;
      chk("async_rst_valid", 32'(ifc.out_valid), 32'd0);
      sb.delete();
      #4;
      @(negedge clk); #2;
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("s1_flushed", 32'(ifc.out_valid), 32'd0);
      end
      @(posedge clk); #1;
      drive(0, 1'b1, 3'd1, 32'h0000_0080, 32'd7);
      drive(1, 1'b1, 3'd0, 32'h0000_0080, 32'd7);
      @(negedge clk);
      chk("post_rst_rdy0", 32'(ifc.req0_ready), 32'd1);
      chk("post_rst_rdy1", 32'(ifc.req1_ready), 32'd0);
      @(posedge clk); #1;
      drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
      @(negedge clk);
      @(posedge clk); #1;
      drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
